// File: rtl/ahb_to_apb_sn.sv
// AHB-to-APB3 bridge for P_NUM slaves in equal 64KB-granular regions.
// Define AHB_TO_APB_APB4_EN to add the APB4 PPROT/PSTRB outputs.
module ahb_to_apb_sn #(
    parameter int          P_NUM     = 4,
    parameter logic [15:0] P_BASE    = 16'hC000,
    parameter logic [15:0] P_SIZE    = 16'h0010,
    parameter int          P_TIMEOUT = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADYin,
    output logic [31:0]          HRDATA,
    output logic [1:0]           HRESP,
    output logic                 HREADYout,
    output logic [P_NUM-1:0]     PSEL,
    output logic                 PENABLE,
    output logic [31:0]          PADDR,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    input  logic [32*P_NUM-1:0]  PRDATA,
    input  logic [P_NUM-1:0]     PREADY,
    input  logic [P_NUM-1:0]     PSLVERR
`ifdef AHB_TO_APB_APB4_EN
    ,
    output logic [2:0]           PPROT,
    output logic [3:0]           PSTRB
`endif
);

    localparam int          IW    = (P_NUM > 1) ? $clog2(P_NUM) : 1;
    localparam bit          TO_EN = (P_TIMEOUT != 0);
    localparam logic [15:0] TO    = 16'(P_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          write_q, write_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic [15:0]   timer_q, timer_d;

    logic          accept;
    logic          hit;
    logic [IW-1:0] idx_dec;
    logic [31:0]   prdata_sel;
    logic          pready_sel;
    logic          pslverr_sel;

    assign accept = HSEL & HREADYin & HTRANS[1];

    // Region bounds widened to 32 bits so the top region cannot wrap
    always_comb begin
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] a;
        hit     = 1'b0;
        idx_dec = '0;
        a       = {16'h0, HADDR[31:16]};
        for (int i = 0; i < P_NUM; i++) begin
            lo = {16'h0, P_BASE} + 32'(i) * {16'h0, P_SIZE};
            hi = lo + {16'h0, P_SIZE};
            if (a >= lo && a < hi) begin
                hit     = 1'b1;
                idx_dec = IW'(i);
            end
        end
    end

    always_comb begin
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        for (int i = 0; i < P_NUM; i++) begin
            if (idx_q == IW'(i)) begin
                prdata_sel  = PRDATA[i*32 +: 32];
                pready_sel  = PREADY[i];
                pslverr_sel = PSLVERR[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        idx_d    = idx_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        timer_d  = timer_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = HADDR;
                    write_d = HWRITE;
                    idx_d   = idx_dec;
                    if (!hit) begin
                        state_d = ERR1;
                        if (!HWRITE) hrdata_d = '0;
                    end else if (HWRITE) begin
                        state_d = WDATA;
                    end else begin
                        state_d = SETUP;
                        timer_d = '0;
                    end
                end
            end
            WDATA: begin
                pwdata_d = HWDATA;
                state_d  = SETUP;
                timer_d  = '0;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (!pready_sel) begin
                    timer_d = timer_q + 16'd1;
                    if (TO_EN && timer_d >= TO) begin
                        state_d = ERR1;
                        if (!write_q) hrdata_d = '0;
                    end
                end else if (pslverr_sel) begin
                    state_d = ERR1;
                    if (!write_q) hrdata_d = '0;
                end else begin
                    state_d = IDLE;
                    if (!write_q) hrdata_d = prdata_sel;
                end
            end
            ERR1:    state_d = ERR2;
            ERR2:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        PSEL = '0;
        for (int i = 0; i < P_NUM; i++) begin
            PSEL[i] = (state_q == SETUP || state_q == ACCESS)
                      && idx_q == IW'(i);
        end
    end

    assign PENABLE   = (state_q == ACCESS);
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = pwdata_q;
    assign HRDATA    = hrdata_q;
    assign HREADYout = (state_q == IDLE) || (state_q == ERR2);
    assign HRESP     = (state_q == ERR1 || state_q == ERR2) ? 2'b01 : 2'b00;

`ifdef AHB_TO_APB_APB4_EN
    logic [2:0] pprot_q;
    logic [3:0] pstrb_q;
    logic [3:0] strb_dec;
    logic       unused_in;

    always_comb begin
        strb_dec = 4'b0000;
        if (HWRITE) begin
            unique case (HSIZE)
                3'b000:  strb_dec = 4'b0001 << HADDR[1:0];
                3'b001:  strb_dec = HADDR[1] ? 4'b1100 : 4'b0011;
                default: strb_dec = 4'b1111;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pprot_q <= '0;
            pstrb_q <= '0;
        end else if (state_q == IDLE && accept) begin
            pprot_q <= {~HPROT[0], 1'b0, HPROT[1]};
            pstrb_q <= strb_dec;
        end
    end

    assign PPROT     = pprot_q;
    assign PSTRB     = pstrb_q;
    assign unused_in = ^{HTRANS[0], HPROT[3:2]};
`else
    logic unused_in;
    assign unused_in = ^{HTRANS[0], HSIZE, HPROT};
`endif

endmodule

// File: tb/tb_ahb_to_apb_sn.sv
// Directed bench for ahb_to_apb_sn: decode, waits, errors, timeout, reset.
// Built with P_TIMEOUT=8 so the timeout path is reachable.
module tb_ahb_to_apb_sn;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         HSEL;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [3:0]   HPROT;
    logic [31:0]  HWDATA;
    logic         HREADYin;
    logic [31:0]  HRDATA;
    logic [1:0]   HRESP;
    logic         HREADYout;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;
    logic [3:0]   PSLVERR;
`ifdef AHB_TO_APB_APB4_EN
    logic [2:0]   PPROT;
    logic [3:0]   PSTRB;
`endif

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    ahb_to_apb_sn #(
        .P_NUM(4), .P_BASE(16'hC000), .P_SIZE(16'h0010), .P_TIMEOUT(8)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADYin(HREADYin), .HRDATA(HRDATA),
        .HRESP(HRESP), .HREADYout(HREADYout), .PSEL(PSEL),
        .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
`ifdef AHB_TO_APB_APB4_EN
        , .PPROT(PPROT), .PSTRB(PSTRB)
`endif
    );

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic w);
        HSEL   = 1'b1;
        HADDR  = a;
        HWRITE = w;
        HTRANS = 2'b10;
    endtask

    task automatic test_reset();
        total++; if (HREADYout !== 1'b1) begin bad++; $display("FAIL rst_hready got=%b exp=1", HREADYout); end
        total++; if (HRESP !== 2'b00) begin bad++; $display("FAIL rst_hresp got=%b exp=00", HRESP); end
        total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", HRDATA); end
        total++; if (PSEL !== 4'b0 || PENABLE !== 1'b0) begin bad++; $display("FAIL rst_psel got=%b/%b exp=0000/0", PSEL, PENABLE); end
        total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin bad++; $display("FAIL rst_apb got=%h/%h/%b exp=0/0/0", PADDR, PWDATA, PWRITE); end
    endtask

    task automatic test_read();
        start(32'hC010_0004, 1'b0);
        step();
        HTRANS = 2'b00;
        total++; if (PSEL !== 4'b0010 || PENABLE !== 1'b0) begin bad++; $display("FAIL rd_setup got=%b/%b exp=0010/0", PSEL, PENABLE); end
        total++; if (HREADYout !== 1'b0) begin bad++; $display("FAIL rd_wait1 got=%b exp=0", HREADYout); end
        total++; if (PADDR !== 32'hC010_0004 || PWRITE !== 1'b0) begin bad++; $display("FAIL rd_paddr got=%h/%b exp=c0100004/0", PADDR, PWRITE); end
        step();
        total++; if (PSEL !== 4'b0010 || PENABLE !== 1'b1) begin bad++; $display("FAIL rd_access got=%b/%b exp=0010/1", PSEL, PENABLE); end
        step();
        total++; if (HREADYout !== 1'b1 || HRESP !== 2'b00) begin bad++; $display("FAIL rd_done got=%b/%b exp=1/00", HREADYout, HRESP); end
        total++; if (HRDATA !== 32'hA5A5_0001) begin bad++; $display("FAIL rd_data got=%h exp=a5a50001", HRDATA); end
        total++; if (PSEL !== 4'b0 || PENABLE !== 1'b0) begin bad++; $display("FAIL rd_drop got=%b/%b exp=0000/0", PSEL, PENABLE); end
    endtask

    task automatic test_write_wait();
        int n;
        PREADY[2] = 1'b0;
        start(32'hC020_0008, 1'b1);
        step();
        HTRANS = 2'b00;
        HWDATA = 32'h1234_5678;
        total++; if (HREADYout !== 1'b0 || PSEL !== 4'b0) begin bad++; $display("FAIL wr_wdata got=%b/%b exp=0/0000", HREADYout, PSEL); end
        step();
        HWDATA = 32'hDEAD_BEEF;
        total++; if (PWDATA !== 32'h1234_5678) begin bad++; $display("FAIL wr_pwdata got=%h exp=12345678", PWDATA); end
        total++; if (PSEL !== 4'b0100 || PENABLE !== 1'b0 || PWRITE !== 1'b1) begin bad++; $display("FAIL wr_setup got=%b/%b/%b exp=0100/0/1", PSEL, PENABLE, PWRITE); end
        step();
        n = 0;
        while (PENABLE === 1'b1 && n < 20) begin
            n++;
            if (n == 4) PREADY[2] = 1'b1;
            step();
        end
        total++; if (n != 4) begin bad++; $display("FAIL wr_access_cycles got=%0d exp=4", n); end
        total++; if (HREADYout !== 1'b1 || HRESP !== 2'b00) begin bad++; $display("FAIL wr_done got=%b/%b exp=1/00", HREADYout, HRESP); end
        total++; if (HRDATA !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_hrdata_hold got=%h exp=a5a50001", HRDATA); end
        PREADY = 4'hF;
    endtask

    task automatic test_unmapped();
        start(32'hD000_0000, 1'b0);
        step();
        HTRANS = 2'b00;
        total++; if (PSEL !== 4'b0) begin bad++; $display("FAIL um_psel got=%b exp=0000", PSEL); end
        total++; if (HRESP !== 2'b01 || HREADYout !== 1'b0) begin bad++; $display("FAIL um_err1 got=%b/%b exp=01/0", HRESP, HREADYout); end
        total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL um_hrdata got=%h exp=0", HRDATA); end
        step();
        total++; if (HRESP !== 2'b01 || HREADYout !== 1'b1) begin bad++; $display("FAIL um_err2 got=%b/%b exp=01/1", HRESP, HREADYout); end
        step();
        total++; if (HRESP !== 2'b00 || HREADYout !== 1'b1) begin bad++; $display("FAIL um_idle got=%b/%b exp=00/1", HRESP, HREADYout); end
    endtask

    task automatic test_decode();
        logic [31:0] addrs [7];
        logic [3:0]  sels  [7];
        logic [31:0] datas [7];
        addrs = '{32'hC000_0000, 32'hC00F_FFFC, 32'hC010_0000, 32'hC03F_FFFC,
                  32'hC040_0000, 32'hBFFF_FFFC, 32'hFFFF_0000};
        sels  = '{4'b0001, 4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        datas = '{32'h1111_0000, 32'h1111_0000, 32'hA5A5_0001, 32'h3333_0003,
                  32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 7; i++) begin
            start(addrs[i], 1'b0);
            step();
            HTRANS = 2'b00;
            total++; if (PSEL !== sels[i]) begin bad++; $display("FAIL dec_psel[%0d] got=%b exp=%b", i, PSEL, sels[i]); end
            total++; if (HRESP !== ((sels[i] == 4'b0) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL dec_hresp[%0d] got=%b", i, HRESP); end
            step();
            step();
            total++; if (HRDATA !== datas[i] || HREADYout !== 1'b1) begin bad++; $display("FAIL dec_data[%0d] got=%h/%b exp=%h/1", i, HRDATA, HREADYout, datas[i]); end
        end
    endtask

    task automatic test_pslverr();
        PSLVERR[1] = 1'b1;
        start(32'hC010_0010, 1'b0);
        step();
        HTRANS = 2'b00;
        step();
        total++; if (PENABLE !== 1'b1 || PSEL !== 4'b0010) begin bad++; $display("FAIL se_access got=%b/%b exp=1/0010", PENABLE, PSEL); end
        step();
        total++; if (PSEL !== 4'b0 || PENABLE !== 1'b0) begin bad++; $display("FAIL se_drop got=%b/%b exp=0000/0", PSEL, PENABLE); end
        total++; if (HRESP !== 2'b01 || HREADYout !== 1'b0 || HRDATA !== 32'h0) begin bad++; $display("FAIL se_err1 got=%b/%b/%h exp=01/0/0", HRESP, HREADYout, HRDATA); end
        step();
        total++; if (HRESP !== 2'b01 || HREADYout !== 1'b1) begin bad++; $display("FAIL se_err2 got=%b/%b exp=01/1", HRESP, HREADYout); end
        PSLVERR = 4'h0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        PREADY[3] = 1'b0;
        start(32'hC030_0000, 1'b0);
        step();
        HTRANS = 2'b00;
        step();
        n = 0;
        while (PENABLE === 1'b1 && n < 30) begin
            n++;
            step();
        end
        total++; if (n != 8) begin bad++; $display("FAIL to_cycles got=%0d exp=8", n); end
        total++; if (PSEL !== 4'b0 || HRESP !== 2'b01 || HREADYout !== 1'b0) begin bad++; $display("FAIL to_err1 got=%b/%b/%b exp=0000/01/0", PSEL, HRESP, HREADYout); end
        step();
        total++; if (HRESP !== 2'b01 || HREADYout !== 1'b1) begin bad++; $display("FAIL to_err2 got=%b/%b exp=01/1", HRESP, HREADYout); end
        PREADY = 4'hF;
        step();
    endtask

    task automatic test_back_to_back();
        start(32'hC000_0000, 1'b0);
        step();
        HTRANS = 2'b00;
        step();
        step();
        total++; if (HREADYout !== 1'b1 || HRDATA !== 32'h1111_0000) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/11110000", HREADYout, HRDATA); end
        start(32'hC020_0000, 1'b0);
        step();
        HTRANS = 2'b00;
        total++; if (PSEL !== 4'b0100 || HREADYout !== 1'b0) begin bad++; $display("FAIL b2b_setup got=%b/%b exp=0100/0", PSEL, HREADYout); end
        step();
        step();
        total++; if (HRDATA !== 32'h2222_0002 || HREADYout !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%b exp=22220002/1", HRDATA, HREADYout); end
    endtask

    task automatic test_ignored();
        start(32'hC000_0000, 1'b0);
        HTRANS = 2'b01;
        step();
        total++; if (PSEL !== 4'b0 || HREADYout !== 1'b1 || HRESP !== 2'b00) begin bad++; $display("FAIL busy_ign got=%b/%b/%b exp=0000/1/00", PSEL, HREADYout, HRESP); end
        HTRANS   = 2'b10;
        HREADYin = 1'b0;
        step();
        total++; if (PSEL !== 4'b0 || HREADYout !== 1'b1) begin bad++; $display("FAIL hrdyin_ign got=%b/%b exp=0000/1", PSEL, HREADYout); end
        HREADYin = 1'b1;
        HSEL     = 1'b0;
        step();
        total++; if (PSEL !== 4'b0 || HREADYout !== 1'b1) begin bad++; $display("FAIL hsel_ign got=%b/%b exp=0000/1", PSEL, HREADYout); end
        HTRANS = 2'b00;
    endtask

    task automatic test_reset_access();
        PREADY[2] = 1'b0;
        start(32'hC020_0004, 1'b1);
        step();
        HTRANS = 2'b00;
        HWDATA = 32'h5555_AAAA;
        step();
        step();
        total++; if (PENABLE !== 1'b1) begin bad++; $display("FAIL ra_in_access got=%b exp=1", PENABLE); end
        HRESETn = 1'b0;
        #1;
        total++; if (PSEL !== 4'b0 || PENABLE !== 1'b0 || HREADYout !== 1'b1 || HRESP !== 2'b00) begin bad++; $display("FAIL ra_ctrl got=%b/%b/%b/%b exp=0000/0/1/00", PSEL, PENABLE, HREADYout, HRESP); end
        total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0 || HRDATA !== 32'h0) begin bad++; $display("FAIL ra_data got=%h/%h/%b/%h exp=0/0/0/0", PADDR, PWDATA, PWRITE, HRDATA); end
        step();
        HRESETn = 1'b1;
        PREADY  = 4'hF;
        step();
        total++; if (HREADYout !== 1'b1 || PSEL !== 4'b0) begin bad++; $display("FAIL ra_after got=%b/%b exp=1/0000", HREADYout, PSEL); end
    endtask

`ifdef AHB_TO_APB_APB4_EN
    task automatic test_apb4();
        HSIZE = 3'b000;
        HPROT = 4'b0010;
        start(32'hC000_0002, 1'b1);
        step();
        HTRANS = 2'b00;
        total++; if (PSTRB !== 4'b0100) begin bad++; $display("FAIL apb4_pstrb got=%b exp=0100", PSTRB); end
        total++; if (PPROT !== 3'b101) begin bad++; $display("FAIL apb4_pprot got=%b exp=101", PPROT); end
        step();
        step();
        step();
        HSIZE = 3'b010;
        start(32'hC000_0000, 1'b0);
        step();
        HTRANS = 2'b00;
        total++; if (PSTRB !== 4'b0000) begin bad++; $display("FAIL apb4_rd_pstrb got=%b exp=0000", PSTRB); end
        step();
        step();
    endtask
`endif

    initial begin
        HRESETn  = 1'b0;
        HSEL     = 1'b0;
        HADDR    = '0;
        HTRANS   = 2'b00;
        HWRITE   = 1'b0;
        HSIZE    = 3'b010;
        HPROT    = 4'b0011;
        HWDATA   = '0;
        HREADYin = 1'b1;
        PRDATA   = {32'h3333_0003, 32'h2222_0002, 32'hA5A5_0001, 32'h1111_0000};
        PREADY   = 4'hF;
        PSLVERR  = 4'h0;
        step();
        step();
        test_reset();
        HRESETn = 1'b1;
        step();
        test_reset();
        test_read();
        test_write_wait();
        test_unmapped();
        test_decode();
        test_pslverr();
        test_timeout();
        test_back_to_back();
        test_ignored();
        test_reset_access();
`ifdef AHB_TO_APB_APB4_EN
        test_apb4();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
